// File: rtl/or1k_div_serial_cappuccino.sv
// Serial restoring divider for l.div / l.divu: one quotient bit per cycle.
// Ports: clk, rst, pipeline_flush_i, start_i, signed_i, rfa_i, rfb_i in;
//        busy_o, valid_o, result_o, overflow_o out.
module or1k_div_serial_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pipeline_flush_i,
  input  logic                            start_i,
  input  logic                            signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rfa_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rfb_i,
  output logic                            busy_o,
  output logic                            valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
  output logic                            overflow_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  div_q;
  logic          neg_q;
  logic          ovf_q;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    rem_sh;
  logic [W:0]    rem_sub;
  logic          ge;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  quo_nx;
  logic [W-1:0]  min_neg;
  logic          ovf_in;

  assign min_neg = {1'b1, {(W-1){1'b0}}};

  // Iterate on magnitudes; the sign is restored in FIXUP.
  assign a_mag = (signed_i & rfa_i[W-1]) ? (W'(0) - rfa_i) : rfa_i;
  assign b_mag = (signed_i & rfb_i[W-1]) ? (W'(0) - rfb_i) : rfb_i;

  // Only -2^(W-1) / -1 overflows once the divisor is known non-zero.
  assign ovf_in = signed_i & (rfa_i == min_neg) & (&rfb_i);

  // The partial remainder pulls in the next dividend bit from the top
  // of the quotient register as it shifts.
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign rem_sub = rem_sh - {1'b0, div_q};
  assign ge      = (rem_sh >= {1'b0, div_q});
  assign rem_nx  = ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
  assign quo_nx  = {quo_q[W-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else if (pipeline_flush_i) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            if (rfb_i == '0) begin
              state      <= DONE;
              busy_o     <= 1'b0;
              valid_o    <= 1'b1;
              result_o   <= '0;
              overflow_o <= 1'b1;
            end else begin
              state   <= BUSY;
              busy_o  <= 1'b1;
              valid_o <= 1'b0;
              cnt     <= CW'(W - 1);
              rem_q   <= '0;
              quo_q   <= a_mag;
              div_q   <= b_mag;
              neg_q   <= signed_i & (rfa_i[W-1] ^ rfb_i[W-1]);
              ovf_q   <= ovf_in;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt == '0) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIXUP: begin
          state      <= DONE;
          busy_o     <= 1'b0;
          valid_o    <= 1'b1;
          result_o   <= neg_q ? (W'(0) - quo_q) : quo_q;
          overflow_o <= ovf_q;
        end
        default: begin
          state   <= IDLE;
          busy_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or1k_div_serial_cappuccino.sv
// Directed bench for the serial divider: latency, signs, boundaries,
// flush, ignored start, back-to-back and asynchronous reset.
module tb_or1k_div_serial_cappuccino;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] rfa = '0;
  logic [31:0] rfb = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  or1k_div_serial_cappuccino #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .pipeline_flush_i(flush),
    .start_i(start),
    .signed_i(sgn),
    .rfa_i(rfa),
    .rfb_i(rfb),
    .busy_o(busy),
    .valid_o(valid),
    .result_o(result),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start pulse; returns just after the sampling edge (edge 0).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s);
    rfa = a;
    rfb = b;
    sgn = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, valid, ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {busy, valid, ovf});
    end
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", result);
    end
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    start_op(32'd100, 32'd7, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL u_busy_e1: got %b expected 1", busy);
    end
    repeat (31) tick();
    checks++;
    if ({busy, valid} !== 2'b10) begin
      errors++;
      $display("FAIL u_e32: got %b expected 10", {busy, valid});
    end
    tick();
    checks++;
    if ({busy, valid, ovf} !== 3'b010) begin
      errors++;
      $display("FAIL u_e33_flags: got %b expected 010", {busy, valid, ovf});
    end
    checks++;
    if (result !== 32'd14) begin
      errors++;
      $display("FAIL u_result: got %h expected %h", result, 32'd14);
    end
  endtask

  task automatic test_signed();
    start_op(32'hFFFFFF9C, 32'd7, 1'b1);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'hFFFFFFF2}) begin
      errors++;
      $display("FAIL s_neg_pos: got %b %b %h expected 1 0 fffffff2",
               valid, ovf, result);
    end
    start_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'd14}) begin
      errors++;
      $display("FAIL s_neg_neg: got %b %b %h expected 1 0 0000000e",
               valid, ovf, result);
    end
    start_op(32'd100, 32'hFFFFFFF9, 1'b1);
    repeat (33) tick();
    checks++;
    if (result !== 32'hFFFFFFF2) begin
      errors++;
      $display("FAIL s_pos_neg: got %h expected fffffff2", result);
    end
  endtask

  task automatic test_boundary();
    start_op(32'd5, 32'd0, 1'b0);
    checks++;
    if ({busy, valid, ovf, result} !== {3'b011, 32'h0}) begin
      errors++;
      $display("FAIL div0: got %b%b%b %h expected 011 0",
               busy, valid, ovf, result);
    end
    tick();
    tick();
    checks++;
    if ({valid, ovf, result} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL div0_hold: got %b%b %h expected 11 0",
               valid, ovf, result);
    end
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b11, 32'h80000000}) begin
      errors++;
      $display("FAIL s_ovf: got %b%b %h expected 11 80000000",
               valid, ovf, result);
    end
    start_op(32'hFFFFFFFF, 32'd1, 1'b0);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL u_max: got %b%b %h expected 10 ffffffff",
               valid, ovf, result);
    end
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b0);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL u_big_div: got %b%b %h expected 10 0",
               valid, ovf, result);
    end
  endtask

  task automatic test_flush();
    start_op(32'd1000, 32'd10, 1'b0);
    repeat (33) tick();
    checks++;
    if (result !== 32'd100) begin
      errors++;
      $display("FAIL f_pre: got %h expected %h", result, 32'd100);
    end
    start_op(32'd50, 32'd5, 1'b0);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({busy, valid, result} !== {2'b00, 32'd100}) begin
      errors++;
      $display("FAIL f_idle: got %b%b %h expected 00 %h",
               busy, valid, result, 32'd100);
    end
    start_op(32'd1234, 32'd3, 1'b0);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'd411}) begin
      errors++;
      $display("FAIL f_restart: got %b%b %h expected 10 %h",
               valid, ovf, result, 32'd411);
    end
    rfa = 32'd9;
    rfb = 32'd3;
    flush = 1'b1;
    start = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, valid} !== 2'b00) begin
      errors++;
      $display("FAIL f_both: got %b expected 00", {busy, valid});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL f_both_late: got %b expected 0", busy);
    end
  endtask

  task automatic test_ignored_start();
    start_op(32'd200, 32'd9, 1'b0);
    repeat (4) tick();
    rfa = 32'd7;
    rfb = 32'd0;
    sgn = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_busy: got %b expected 1", busy);
    end
    repeat (28) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'd22}) begin
      errors++;
      $display("FAIL ign_result: got %b%b %h expected 10 %h",
               valid, ovf, result, 32'd22);
    end
  endtask

  task automatic test_back_to_back();
    start_op(32'd81, 32'd9, 1'b0);
    checks++;
    if ({busy, valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: got %b expected 10", {busy, valid});
    end
    repeat (33) tick();
    checks++;
    if ({valid, result} !== {1'b1, 32'd9}) begin
      errors++;
      $display("FAIL b2b_result: got %b %h expected 1 %h",
               valid, result, 32'd9);
    end
    start_op(32'd3, 32'd0, 1'b0);
    checks++;
    if ({valid, ovf, result} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL b2b_div0: got %b%b %h expected 11 0",
               valid, ovf, result);
    end
    start_op(32'd10, 32'd2, 1'b0);
    repeat (33) tick();
    checks++;
    if ({valid, ovf, result} !== {2'b10, 32'd5}) begin
      errors++;
      $display("FAIL b2b_clear_ovf: got %b%b %h expected 10 %h",
               valid, ovf, result, 32'd5);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (14) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, valid, ovf, result} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid: got %b%b%b %h expected 000 0",
               busy, valid, ovf, result);
    end
    tick();
    #3 rst = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_after: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundary();
    test_flush();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
